// File: rtl/pcie_wr_sched_pkg.sv
// Shared constants and FSM encoding for the to-host write scheduler and its page table.
package pcie_wr_sched_pkg;

    localparam int BLK_BYTES     = 128;
    localparam int BEATS         = 16;
    localparam int BLKS_PER_PAGE = 32;

    localparam int BLK_SHIFT = $clog2(BLK_BYTES);
    localparam int BEAT_W    = $clog2(BEATS);
    localparam int BLK_W     = $clog2(BLKS_PER_PAGE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REQ,
        S_BURST,
        S_UPDATE
    } sched_state_t;

endpackage

// File: rtl/pcie_page_table.sv
// Per-channel host page table: simple dual-port RAM, one synchronous read port.
// A write and a read of the same entry on one edge returns the old contents.
module pcie_page_table #(
    parameter int NCH   = 2,
    parameter int PAGES = 32,
    parameter int AW    = $clog2(NCH * PAGES)
) (
    input  logic          clock,
    input  logic          wvalid,
    input  logic [AW-1:0] waddr,
    input  logic [51:0]   wdata,
    input  logic          rvalid,
    input  logic [AW-1:0] raddr,
    output logic [51:0]   rdata
);

    logic [51:0] mem [NCH*PAGES];

    // Read holds its value between lookups so the request address stays stable
    always_ff @(posedge clock) begin
        if (wvalid) begin
            mem[waddr] <= wdata;
        end
        if (rvalid) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pcie_wr_sched.sv
// Round-robin scheduler turning per-channel 16-word FIFO bursts into 128-byte
// host writes, addressed through a per-channel page table.
module pcie_wr_sched
    import pcie_wr_sched_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int PAGES = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NCH-1:0]           ch_enable,
    input  logic [NCH-1:0]           ch_avail16,
    input  logic [64*NCH-1:0]        ch_data,
    output logic [NCH-1:0]           ch_read,
    input  logic                     pt_wvalid,
    input  logic [1:0]               pt_ch,
    input  logic [$clog2(PAGES)-1:0] pt_index,
    input  logic [51:0]              pt_addr,
    output logic                     wr_valid,
    output logic [63:0]              wr_addr,
    input  logic                     wr_ready,
    output logic [63:0]              wr_data,
    output logic [32*NCH-1:0]        ch_blocks
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW = $clog2(PAGES);
    localparam int AW = $clog2(NCH * PAGES);

    sched_state_t state, state_next;

    logic [CW-1:0]     grant;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     pick;
    logic              pick_valid;
    logic [NCH-1:0]    eligible;
    logic [BEAT_W-1:0] beat;
    logic              busy;

    logic [BLK_W-1:0]  blk_off  [NCH];
    logic [IW-1:0]     page_idx [NCH];
    logic [31:0]       blocks   [NCH];

    logic              pt_we;
    logic              pt_re;
    logic [AW-1:0]     pt_waddr;
    logic [AW-1:0]     pt_raddr;
    logic [51:0]       pt_entry;

    assign busy     = (state != S_IDLE);
    assign eligible = ch_enable & ch_avail16;
    assign pt_we    = pt_wvalid && (int'(pt_ch) < NCH);
    assign pt_waddr = AW'({pt_ch, pt_index});
    assign pt_raddr = AW'({grant, page_idx[grant]});
    assign pt_re    = (state == S_LOOKUP);

    pcie_page_table #(
        .NCH   (NCH),
        .PAGES (PAGES),
        .AW    (AW)
    ) u_page_table (
        .clock  (clock),
        .wvalid (pt_we),
        .waddr  (pt_waddr),
        .wdata  (pt_addr),
        .rvalid (pt_re),
        .raddr  (pt_raddr),
        .rdata  (pt_entry)
    );

    // Lowest offset from rr_ptr wins because later iterations overwrite earlier ones
    always_comb begin
        pick_valid = 1'b0;
        pick       = rr_ptr;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (eligible[(int'(rr_ptr) + i) % NCH]) begin
                pick_valid = 1'b1;
                pick       = CW'((int'(rr_ptr) + i) % NCH);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_valid   = 1'b0;
        ch_read    = '0;
        unique case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                wr_valid       = 1'b1;
                ch_read[grant] = wr_ready;
                if (wr_ready) begin
                    state_next = S_BURST;
                end
            end
            S_BURST: begin
                ch_read[grant] = wr_ready;
                if (wr_ready && beat == BEAT_W'(BEATS - 1)) begin
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // A burst cut by reset must not pop any more words
        if (reset) begin
            wr_valid = 1'b0;
            ch_read  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant  <= '0;
            rr_ptr <= '0;
            beat   <= '0;
        end else begin
            if (state == S_IDLE && pick_valid) begin
                grant  <= pick;
                rr_ptr <= (pick == CW'(NCH - 1)) ? '0 : pick + 1'b1;
            end
            if ((state == S_REQ || state == S_BURST) && wr_ready) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // A disabled channel forgets its position unless it owns the request in flight
    always_ff @(posedge clock) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset || (!ch_enable[i] && !(busy && grant == CW'(i)))) begin
                blk_off[i]  <= '0;
                page_idx[i] <= '0;
                blocks[i]   <= '0;
            end else if (state == S_UPDATE && grant == CW'(i)) begin
                blk_off[i] <= blk_off[i] + 1'b1;
                if (blk_off[i] == BLK_W'(BLKS_PER_PAGE - 1)) begin
                    page_idx[i] <= page_idx[i] + IW'(1);
                end
                blocks[i] <= blocks[i] + 32'd1;
            end
        end
    end

    assign wr_addr = {pt_entry, blk_off[grant], {BLK_SHIFT{1'b0}}};

    always_comb begin
        wr_data = ch_data[63:0];
        for (int i = 1; i < NCH; i++) begin
            if (grant == CW'(i)) begin
                wr_data = ch_data[64*i +: 64];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_blocks
        assign ch_blocks[32*g +: 32] = blocks[g];
    end

endmodule
